// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types, sizes and helpers for the truth-table sweep reader
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_VEC   = 16;
  localparam int IN_W      = 4;
  localparam int OUT_TOG_W = 4;
  localparam int IN_TOG_W  = 5;

  // Number of set bits in one input vector, sized for the input toggle total
  function automatic logic [IN_TOG_W-1:0] vec_popcount(input logic [IN_W-1:0] v);
    logic [IN_TOG_W-1:0] n;
    n = '0;
    for (int i = 0; i < IN_W; i++) begin
      n = n + {{(IN_TOG_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tt_order_gen.sv
// rtl/tt_order_gen.sv - maps a sweep index to the vector applied at that step
module tt_order_gen
  import tt_sweep_pkg::*;
#(
  parameter int ORDER = 0
) (
  input  logic [IN_W-1:0] idx,
  output logic [IN_W-1:0] vec
);

  // Reflected Gray order changes one input bit per step; binary order is the identity
  generate
    if (ORDER == 1) begin : g_gray
      assign vec = idx ^ (idx >> 1);
    end else begin : g_bin
      assign vec = idx;
    end
  endgenerate

endmodule

// File: rtl/tt_sweep_reader.sv
// rtl/tt_sweep_reader.sv - sweeps all 16 input vectors and records the response truth table
module tt_sweep_reader
  import tt_sweep_pkg::*;
#(
  parameter int ORDER  = 0,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [IN_W-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic [NUM_VEC-1:0]   truth_table,
  output logic [OUT_TOG_W-1:0] out_tog_cnt,
  output logic [IN_TOG_W-1:0]  in_tog_cnt
);

  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
  localparam logic [IN_W-1:0] LAST_IDX = IN_W'(NUM_VEC - 1);

  state_t          state;
  logic [IN_W-1:0] idx;
  logic [3:0]      hold_cnt;
  logic            prev_sample;
  logic [IN_W-1:0] gen_idx;
  logic [IN_W-1:0] gen_vec;

  // In HOLD the generator looks one step ahead; in IDLE it yields the first vector
  always_comb begin
    gen_idx = '0;
    if (state == ST_HOLD) begin
      gen_idx = idx + 4'd1;
    end
  end

  tt_order_gen #(
    .ORDER(ORDER)
  ) u_order_gen (
    .idx(gen_idx),
    .vec(gen_vec)
  );

  // Sweep control: hold each vector SETTLE+1 cycles, capture on the last, abort wins over capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      hold_cnt     <= '0;
      prev_sample  <= 1'b0;
      dut_in       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      truth_table  <= '0;
      out_tog_cnt  <= '0;
      in_tog_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state        <= ST_HOLD;
            busy         <= 1'b1;
            idx          <= '0;
            dut_in       <= gen_vec;
            hold_cnt     <= SETTLE_L;
            truth_table  <= '0;
            out_tog_cnt  <= '0;
            in_tog_cnt   <= '0;
            result_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (abort) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            dut_in <= '0;
          end else if (hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
          end else begin
            truth_table[dut_in] <= dut_out;
            prev_sample         <= dut_out;
            if ((idx != '0) && (dut_out != prev_sample)) begin
              out_tog_cnt <= out_tog_cnt + {{(OUT_TOG_W-1){1'b0}}, 1'b1};
            end
            if (idx == LAST_IDX) begin
              state        <= ST_DONE;
              done         <= 1'b1;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              dut_in       <= '0;
            end else begin
              idx        <= idx + 4'd1;
              dut_in     <= gen_vec;
              hold_cnt   <= SETTLE_L;
              in_tog_cnt <= in_tog_cnt + vec_popcount(dut_in ^ gen_vec);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_reader.sv
// tb/tb_tt_sweep_reader.sv - randomized self-checking bench for tt_sweep_reader
module tb_tt_sweep_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start_v;
  logic [2:0]  abort_v;
  wire  [2:0]  dout;
  wire  [2:0]  busy_v;
  wire  [2:0]  done_v;
  wire  [2:0]  rv_v;
  logic [3:0]  din   [3];
  logic [15:0] tt_v  [3];
  logic [3:0]  otc_v [3];
  logic [4:0]  itc_v [3];
  logic [15:0] fn_tt;

  int checks = 0;
  int errors = 0;

  // Instance 0: binary/SETTLE=1, instance 1: Gray/SETTLE=1, instance 2: binary/SETTLE=3
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      tt_sweep_reader #(
        .ORDER((g == 1) ? 1 : 0),
        .SETTLE((g == 2) ? 3 : 1)
      ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start_v[g]),
        .abort(abort_v[g]),
        .dut_in(din[g]),
        .dut_out(dout[g]),
        .busy(busy_v[g]),
        .done(done_v[g]),
        .result_valid(rv_v[g]),
        .truth_table(tt_v[g]),
        .out_tog_cnt(otc_v[g]),
        .in_tog_cnt(itc_v[g])
      );
      assign dout[g] = fn_tt[din[g]];
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ordv(input int o, input int i);
    logic [3:0] x;
    x = i[3:0];
    return (o == 1) ? (x ^ (x >> 1)) : x;
  endfunction

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_flags"}, {busy_v[k], done_v[k], rv_v[k]}, 0);
    chk({tag, "_din"}, din[k], 0);
    chk({tag, "_tt"}, tt_v[k], 0);
    chk({tag, "_cnt"}, {otc_v[k], itc_v[k]}, 0);
  endtask

  // One sweep on instance k; abort_idx<0 means run to completion, poke_idx>=0 pulses start mid-run
  task automatic run_sweep(input int k, input logic [15:0] f, input int abort_idx,
                           input int abort_off, input int poke_idx);
    int s, o, per, total, n, abort_edge, done_cnt, done_at, din_err, c, up, exp_ot, exp_it;
    logic busy_d, rv_d;
    logic [15:0] exp_tt;
    logic [3:0] v;
    s = (k == 2) ? 3 : 1;
    o = (k == 1) ? 1 : 0;
    per = s + 1;
    total = 16 * per;
    fn_tt = f;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    chk("start_busy", busy_v[k], 1);
    chk("start_clear", {rv_v[k], tt_v[k], otc_v[k], itc_v[k]}, 0);
    chk("start_din", din[k], ordv(o, 0));
    abort_edge = (abort_idx >= 0) ? abort_idx * per + 1 + abort_off : -1;
    done_cnt = 0; done_at = -1; din_err = 0; busy_d = 1'b1; rv_d = 1'b0;
    for (n = 1; n <= total + 3; n++) begin
      if (n == abort_edge) abort_v[k] = 1'b1;
      if (poke_idx >= 0 && n == poke_idx * per + 1) start_v[k] = 1'b1;
      tick();
      abort_v[k] = 1'b0;
      start_v[k] = 1'b0;
      if (done_v[k]) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == abort_edge) break;
      if (n == total) begin
        busy_d = busy_v[k];
        rv_d = rv_v[k];
      end
      if (n < total) begin
        if (din[k] !== ordv(o, n / per)) din_err++;
      end else if (din[k] !== 4'd0) begin
        din_err++;
      end
    end
    c = (abort_idx >= 0) ? abort_idx : 16;
    up = (c == 16) ? 15 : c;
    exp_tt = '0; exp_ot = 0; exp_it = 0;
    for (int j = 0; j < c; j++) begin
      v = ordv(o, j);
      exp_tt[v] = f[v];
      if (j > 0 && f[v] != f[ordv(o, j - 1)]) exp_ot++;
    end
    for (int j = 1; j <= up; j++) exp_it += $countones(ordv(o, j) ^ ordv(o, j - 1));
    chk("din_seq", din_err, 0);
    if (abort_idx >= 0) begin
      chk("abort_busy", busy_v[k], 0);
      chk("abort_din", din[k], 0);
      repeat (3) begin
        tick();
        if (done_v[k]) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);
      chk("abort_rv", rv_v[k], 0);
    end else begin
      chk("done_cnt", done_cnt, 1);
      chk("done_time", done_at, total);
      chk("done_busy", busy_d, 0);
      chk("done_rv", rv_d, 1);
      chk("hold_rv", rv_v[k], 1);
      chk("idle_busy", busy_v[k], 0);
    end
    chk("tt", tt_v[k], exp_tt);
    chk("out_tog", otc_v[k], exp_ot);
    chk("in_tog", itc_v[k], exp_it);
  endtask

  logic [15:0] fx, fn3;
  int rk, ra, ro, rp;

  initial begin
    rst_n = 1'b0;
    start_v = '0;
    abort_v = '0;
    fn_tt = '0;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv = v[3:0];
      fx[v] = vv[0] ^ vv[1];
      fn3[v] = ~vv[3];
    end
    repeat (3) tick();
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");
    rst_n = 1'b1;
    tick();

    run_sweep(0, fx, -1, 0, -1);
    chk("bin_tt_const", tt_v[0], 16'h6666);
    chk("bin_otc_const", otc_v[0], 8);
    chk("bin_itc_const", itc_v[0], 26);

    run_sweep(1, fx, -1, 0, -1);
    chk("gray_tt_const", tt_v[1], 16'h6666);
    chk("gray_otc_const", otc_v[1], 12);
    chk("gray_itc_const", itc_v[1], 15);

    run_sweep(2, 16'hFFFF, -1, 0, -1);
    chk("ones_tt_const", tt_v[2], 16'hFFFF);
    chk("ones_otc_const", otc_v[2], 0);

    run_sweep(0, fn3, -1, 0, -1);
    chk("nd3_tt_const", tt_v[0], 16'h00FF);
    chk("nd3_otc_const", otc_v[0], 1);

    run_sweep(0, fx, 7, $urandom_range(0, 1), -1);
    chk("abort_hi_bits", tt_v[0][15:8], 0);

    run_sweep(0, fx, 15, 1, -1);
    run_sweep(0, fx, -1, 0, 5);
    run_sweep(0, fx, -1, 0, 16);

    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("start_abort_idle", busy_v[0], 0);

    fn_tt = fx;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (20) tick();
    chk("pre_reset_din", din[0], 4'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(0, "async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    run_sweep(0, fx, -1, 0, -1);

    for (int r = 0; r < 8; r++) begin
      rk = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        ra = $urandom_range(0, 15);
        ro = $urandom_range(0, (rk == 2) ? 3 : 1);
        rp = -1;
      end else begin
        ra = -1;
        ro = 0;
        rp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 16) : -1;
      end
      run_sweep(rk, 16'($urandom), ra, ro, rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
